// File: rtl/mb_lane_pattern_checker_pkg.sv
// Shared MBINIT definitions: PRBS23 polynomial and seed, checker FSM
// encoding, mainband lane count, and a single-step PRBS23 helper.
package mb_lane_pattern_checker_pkg;

  localparam int MB_LANES = 16;
  localparam int PRBS23_W = 23;

  // x^23+x^21+x^18+x^15+x^7+x^2+1 : term x^k taps state bit k-1.
  localparam logic [PRBS23_W-1:0] PRBS23_TAPS = 23'h524042;
  // Lane-0 load value.
  localparam logic [PRBS23_W-1:0] PRBS23_SEED = 23'h1DBFBC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_EVAL    = 2'd2,
    ST_DONE    = 2'd3
  } mb_chk_state_e;

  // Fibonacci step, shifting toward the MSB; new bit enters at bit 0.
  function automatic logic [PRBS23_W-1:0] prbs23_step(input logic [PRBS23_W-1:0] s);
    return {s[PRBS23_W-2:0], ^(s & PRBS23_TAPS)};
  endfunction

endpackage

// File: rtl/mb_lane_pattern_checker_prbs.sv
// mb_prbs23_gen: PRBS23 state register with load and advance.
// Ports:
//   CLK, rst_n : clock, async active-low reset (state resets to SEED)
//   load_i     : reload SEED (wins over adv_i)
//   adv_i      : advance one PRBS step
//   state_o    : current 23-bit state
module mb_prbs23_gen
  import mb_lane_pattern_checker_pkg::*;
#(
  parameter logic [PRBS23_W-1:0] SEED = PRBS23_SEED
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                adv_i,
  output logic [PRBS23_W-1:0] state_o
);

  logic [PRBS23_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = SEED;
    else if (adv_i) lfsr_d = prbs23_step(lfsr_q);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mb_lane_pattern_checker.sv
// MBINIT receive-side lane checker. Compares NUM_LANES received samples
// against the local PRBS23 over ITERATIONS valid cycles, keeps a saturating
// error count per lane, and publishes a per-lane pass vector.
// Ports:
//   CLK, rst_n     : clock, async active-low reset
//   i_start        : begin a run (IDLE only)
//   i_abort        : return to IDLE, no done pulse, result kept
//   i_lane_valid   : qualifies i_lane_data
//   i_lane_data    : one sample per lane
//   o_Transmitter_initiated_Data_to_CLK_Result : bit i = lane i passed
//   o_done         : one-cycle pulse when a new result is visible
//   o_busy         : high outside IDLE
module mb_lane_pattern_checker
  import mb_lane_pattern_checker_pkg::*;
#(
  parameter int                  NUM_LANES     = MB_LANES,
  parameter int                  ITERATIONS    = 128,
  parameter int                  CNT_W         = 8,
  parameter int                  ERR_THRESHOLD = 0,
  parameter logic [PRBS23_W-1:0] LFSR_SEED     = PRBS23_SEED
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_lane_valid,
  input  logic [NUM_LANES-1:0] i_lane_data,
  output logic [NUM_LANES-1:0] o_Transmitter_initiated_Data_to_CLK_Result,
  output logic                 o_done,
  output logic                 o_busy
);

  localparam int                SCNT_W   = $clog2(ITERATIONS + 1);
  localparam logic [SCNT_W-1:0] LAST_SMP = SCNT_W'(ITERATIONS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  mb_chk_state_e                         state_q, state_d;
  logic          [SCNT_W-1:0]            smp_cnt_q, smp_cnt_d;
  logic          [NUM_LANES-1:0][CNT_W-1:0] err_cnt_q;
  logic          [NUM_LANES-1:0]         result_q, pass;
  logic          [PRBS23_W-1:0]          lfsr;
  logic          [NUM_LANES-1:0]         mism;
  logic                                  start_acc, smp_acc, eval;

  mb_prbs23_gen #(.SEED(LFSR_SEED)) u_prbs (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .load_i  (start_acc),
    .adv_i   (smp_acc),
    .state_o (lfsr)
  );

  // Upper PRBS bits only feed the polynomial, not the lane compare.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr[PRBS23_W-1:NUM_LANES];

  // Abort outranks every transition, including a start in IDLE.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    smp_acc   = 1'b0;
    eval      = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_start) begin
          start_acc = 1'b1;
          state_d   = ST_COMPARE;
        end
        ST_COMPARE: if (i_lane_valid) begin
          smp_acc = 1'b1;
          if (smp_cnt_q == LAST_SMP) state_d = ST_EVAL;
        end
        ST_EVAL: begin
          eval    = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    if (start_acc)    smp_cnt_d = '0;
    else if (smp_acc) smp_cnt_d = smp_cnt_q + SCNT_W'(1);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Every lane compares against the same PRBS word in the same cycle.
  assign mism = i_lane_data ^ lfsr[NUM_LANES-1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
        err_cnt_q[l] <= '0;
      else if (start_acc)
        err_cnt_q[l] <= '0;
      else if (smp_acc && mism[l] && (err_cnt_q[l] != CNT_MAX))
        err_cnt_q[l] <= err_cnt_q[l] + CNT_W'(1);
    end
    assign pass[l] = (int'(err_cnt_q[l]) <= ERR_THRESHOLD);
  end

  // Result only changes in EVAL; start/abort leave the last verdict visible.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)    result_q <= '0;
    else if (eval) result_q <= pass;
  end

  assign o_Transmitter_initiated_Data_to_CLK_Result = result_q;
  assign o_done = (state_q == ST_DONE);
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: doc/mb_lane_pattern_checker.md
Name: mb_lane_pattern_checker

Overview:
- MBINIT receive-side checker that feeds Functional_Lane_Setup.
- Compares 16 mainband lane samples against a locally generated UCIe PRBS23 pattern over a fixed number of valid cycles.
- Accumulates a saturating error count per lane and produces the 16-bit per-lane pass/fail vector consumed as i_Transmitter_initiated_Data_to_CLK_Result.

Parameters:
- NUM_LANES, 16, number of mainband data lanes checked.
- ITERATIONS, 128, number of valid comparison cycles per run (range 1..65535).
- CNT_W, 8, width of each per-lane error counter.
- ERR_THRESHOLD, 0, maximum error count for which a lane passes.
- LFSR_SEED, 23'h1DBFBC, PRBS23 load value on each start.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  reset.
- i_start  in  1  single-cycle request to begin a run; accepted only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE.
- i_lane_valid  in  1  qualifies i_lane_data for this cycle.
- i_lane_data  in  NUM_LANES  one received sample per lane per cycle.
- o_Transmitter_initiated_Data_to_CLK_Result  out  NUM_LANES  bit i = 1 means lane i passed.
- o_done  out  1  one-cycle pulse; result valid from this cycle onward.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is CLK, rising edge.
- Reset values:
  - result = 0, o_done = 0, o_busy = 0.
  - State = IDLE; LFSR = LFSR_SEED; all error and sample counters = 0.
- PRBS23 polynomial: x^23+x^21+x^18+x^15+x^7+x^2+1, Fibonacci form, shifting toward the MSB.
- Expected word = LFSR[NUM_LANES-1:0]; the same LFSR state serves all lanes.
- FSM states: IDLE, COMPARE, EVAL, DONE.
- IDLE:
  - On i_start, load LFSR with LFSR_SEED, clear error and sample counters, then go to COMPARE.
  - o_busy rises in the following cycle.
- COMPARE, each cycle with i_lane_valid = 1:
  - err_cnt[i] increments when i_lane_data[i] != expected[i].
  - Each err_cnt saturates at 2^CNT_W-1 (no wrap).
  - The LFSR advances one step and the sample counter increments.
- COMPARE, cycles with i_lane_valid = 0: nothing changes.
- COMPARE exits to EVAL once the sample counter reaches ITERATIONS. The comparison in that final valid cycle is included in the counts.
- EVAL, one cycle: register result[i] = (err_cnt[i] <= ERR_THRESHOLD), then go to DONE.
- DONE, one cycle: o_done = 1, then go to IDLE.
- Latency with continuous valid:
  - i_start at cycle 0; compare cycles 1..ITERATIONS.
  - EVAL at ITERATIONS+1; o_done at ITERATIONS+2.
  - The new result is visible in the o_done cycle.
- Result holds its value from EVAL until the next EVAL. It is not cleared by i_start or i_abort.
- i_start while o_busy = 1 is ignored.
- i_abort in any non-IDLE state:
  - Next state is IDLE; no o_done pulse; result unchanged.
  - i_abort has priority over every other transition.
- i_start and i_abort together in IDLE: abort wins and the start is dropped.
- rst_n asserted mid-run: immediate return to reset values; no o_done pulse.
- Sample counter width is $clog2(ITERATIONS+1).

Decomposition:
- Shared MBINIT package holds:
  - PRBS23 polynomial taps and the lane-0 seed constant.
  - FSM state encoding.
  - MB_LANES = 16 constant.
- One natural sub-module, mb_prbs23_gen: load, advance, 23-bit state out; reused by the transmit pattern generator.

Test Plan:
- Clean run: ITERATIONS=128, i_lane_data equals the golden PRBS23 LSBs, continuous valid, i_start at cycle 0 -> o_done at cycle 130, result 16'hFFFF, o_busy high cycles 1..130.
- Single-lane fault: lane 3 inverted on one sample, ERR_THRESHOLD=0 -> result 16'hFFF7; same stimulus with ERR_THRESHOLD=1 -> 16'hFFFF.
- Half-width fault: lanes 0..7 stuck at 0 -> result 16'hFF00; feeding this into Functional_Lane_Setup yields o_Functional_Lanes = 2'b10.
- Valid gaps: valid toggling 1,0,1,0 with correct data -> exactly 128 valid samples counted, o_done at cycle 257, result 16'hFFFF.
- Saturation: CNT_W=2, lane 15 fully inverted -> err_cnt[15] holds at 3 with no wrap, result[15] = 0.
- Abort and restart:
  - i_abort at cycle 50 -> IDLE next cycle, no o_done, result retains the prior 16'hFF00.
  - A following clean run with i_start -> 16'hFFFF.
  - i_start pulsed at cycle 60 while busy -> ignored.
